microsequencer: RTL and testbench
=================================

# microsequencer

Next-address controller for the 112-bit microcode control word. Each clock it reads the current step's sequencing fields (typ, offset, condition select/invert/source, escape), evaluates the selected condition and registers the next micro-address. That address drives all fourteen u-ROM chips. It sits between the instruction register, flag registers and interrupt controller on one side and the u-ROM bank on the other.

## Interface
- `UADDR_W`, 15: micro-address width; {escape, opcode[7:0], step[5:0]}.
- `FETCH_ENTRY`, 15'h0000: first step of the fetch routine.
- `TRAP_ENTRY`, 15'h0040: first step of the interrupt entry routine.
- `clk` in 1: the only clock.
- `rst` in 1: reset. Synchronous, active-high.
- `cw` in CONTROL_WORD_WIDTH: control word currently read from u-ROM at `u_addr`; combinational ROM.
- `ir_opcode` in 8: instruction register contents.
- `flags` in 4: CPU flags {OF,SF,CF,ZF}.
- `u_flags` in 4: micro-flags {OF,SF,CF,ZF}.
- `int_pending` in 1: an unmasked interrupt is waiting.
- `irq_en` in 1: status bit `irq_en`.
- `dma_req` in 1: DMA request.
- `mode` in 1: status bit `mode` (1 = supervisor).
- `mem_wait` in 1: memory not ready; stall the sequencer.
- `ext_cond` in 1: spare board condition input.
- `u_addr` out UADDR_W: registered micro-address.
- `cond_true` out 1: condition result for the current step after inversion; combinational.
- `dispatch` out 1: pulses for one cycle when `u_addr` was loaded from the opcode.
- `escape_active` out 1: escape latch state.
- `in_trap` out 1: `u_addr` was loaded with `TRAP_ENTRY` on the last update.

## Operation
- Decoded fields from `cw`:
  - typ = bits 1:0.
  - offset = bits 8:2, 7-bit two's complement.
  - cond_invert = bit 9.
  - cond_flag_src = bit 10 (0 = `flags`, 1 = `u_flags`).
  - cond_sel = bits 14:11.
  - escape = bit 15.
- Condition select `cond_sel` (F is the flag set chosen by `cond_flag_src`):
  - 0: ZF. 1: CF. 2: SF. 3: OF.
  - 4: SF^OF. 5: ZF|(SF^OF). 6: CF|ZF.
  - 7: `dma_req`. 8: `mode`. 9: `int_pending & irq_en`. 10: `ext_cond`.
  - 11: constant 1. 12–15: constant 0.
- `cond_true` = selected condition XOR cond_invert.
- Next address by typ:
  - 00 OFFSET: taken → `u_addr` + sign-extended offset; else `u_addr`+1. Arithmetic wraps modulo 2^UADDR_W.
  - 01 BRANCH: taken → {`u_addr`[14:6], offset[5:0]} (absolute within the current 64-step page); else `u_addr`+1.
  - 10 DISPATCH: → {escape_q, `ir_opcode`, 6'd0}. `dispatch`=1. escape_q clears.
  - 11 END: if `int_pending & irq_en` → `TRAP_ENTRY` and `in_trap`=1; else `FETCH_ENTRY`. Condition is ignored.
- Escape latch:
  - escape bit set on a non-DISPATCH step → escape_q=1 on the next update.
  - escape bit set on a DISPATCH step → escape_q still clears (the dispatch uses the old value).
- Stall: `mem_wait`=1 holds `u_addr`, escape_q and `in_trap`, and forces `dispatch`=0. `cond_true` stays live.

## Timing
- One micro-step per unstalled cycle. `u_addr` updates on the rising `clk` edge after `cw` is presented. Latency from `cw` to `u_addr` is 1 cycle.
- `rst` overrides everything, including `mem_wait`. After the reset edge:
  - `u_addr`=`FETCH_ENTRY`.
  - escape_q=0, `dispatch`=0, `in_trap`=0.
- Reset mid-routine abandons the routine. There is no restart state.
- `dispatch` and `in_trap` are registered. They are high for exactly the cycle whose `u_addr` came from the DISPATCH or trap load.
- Simultaneous `int_pending` and `dma_req` at END: the trap wins. DMA is tested only by an explicit cond_sel 7 step.
- OFFSET past 0x7FFF wraps to 0x0000. Backward offset below 0 wraps to the top. No error is flagged.

## Structure
- Add to shared package `pa_microcode`:
  - typ encoding enum (`TYP_OFFSET`, `TYP_BRANCH`, `TYP_DISPATCH`, `TYP_END`).
  - cond_sel enum.
  - `UADDR_W`, `FETCH_ENTRY`, `TRAP_ENTRY` constants.
  - Field positions for typ/offset/cond already exist there and are reused.
- One sub-module, `cond_mux`: purely combinational condition select plus invert.
- The address register, escape latch and typ decode live in the top.

## Test plan
- Reset with `mem_wait`=1 → `u_addr`=0x0000, `escape_active`=0, `dispatch`=0.
- `u_addr`=0x0105, typ 00, offset 7'h7D (−3), cond_sel 11 → 0x0102. Same step with cond_sel 12 → 0x0106.
- `u_addr`=0x0140, typ 01, offset 0x15, cond_sel 0, flags ZF=1, invert 0 → 0x0155. With invert=1 → 0x0141.
- Escape step at 0x0003, then typ 10 with `ir_opcode`=0x2A → 0x4A80 and `dispatch`=1 for one cycle. Next DISPATCH with opcode 0x2A → 0x0A80.
- typ 11 with `int_pending`=1, `irq_en`=1 → 0x0040 and `in_trap`=1. With `irq_en`=0 → 0x0000.
- Hold `mem_wait`=1 for 3 cycles on an OFFSET step → `u_addr` unchanged. Advances on the first cycle after release. Also check 0x7FFF + 1 → 0x0000.

Source files
------------

// File: rtl/pa_microcode.sv
// Shared microcode definitions: control-word field positions, sequencing
// encodings and the fixed micro-address entry points.
package pa_microcode;

  localparam int CONTROL_WORD_WIDTH = 112;

  localparam int TYP_LSB   = 0;
  localparam int TYP_W     = 2;
  localparam int OFF_LSB   = 2;
  localparam int OFF_W     = 7;
  localparam int CINV_BIT  = 9;
  localparam int CSRC_BIT  = 10;
  localparam int CSEL_LSB  = 11;
  localparam int CSEL_W    = 4;
  localparam int ESC_BIT   = 15;

  localparam int UADDR_W = 15;
  localparam logic [UADDR_W-1:0] FETCH_ENTRY = 15'h0000;
  localparam logic [UADDR_W-1:0] TRAP_ENTRY  = 15'h0040;

  typedef enum logic [1:0] {
    TYP_OFFSET   = 2'b00,
    TYP_BRANCH   = 2'b01,
    TYP_DISPATCH = 2'b10,
    TYP_END      = 2'b11
  } typ_e;

  typedef enum logic [3:0] {
    COND_ZF    = 4'd0,
    COND_CF    = 4'd1,
    COND_SF    = 4'd2,
    COND_OF    = 4'd3,
    COND_LT    = 4'd4,
    COND_LE    = 4'd5,
    COND_BE    = 4'd6,
    COND_DMA   = 4'd7,
    COND_MODE  = 4'd8,
    COND_IRQ   = 4'd9,
    COND_EXT   = 4'd10,
    COND_TRUE  = 4'd11
  } cond_sel_e;

endpackage

// File: rtl/microsequencer_cond_mux.sv
// Combinational branch-condition select and invert for the sequencer.
module cond_mux
  import pa_microcode::*;
(
  input  logic [3:0] cond_sel,
  input  logic       cond_invert,
  input  logic       cond_flag_src,
  input  logic [3:0] flags,
  input  logic [3:0] u_flags,
  input  logic       int_pending,
  input  logic       irq_en,
  input  logic       dma_req,
  input  logic       mode,
  input  logic       ext_cond,
  output logic       cond_true
);

  logic [3:0] f;
  logic       zf, cf, sf, of_;
  logic       sel_val;

  // Flag nibble layout is {OF,SF,CF,ZF}
  assign f   = cond_flag_src ? u_flags : flags;
  assign zf  = f[0];
  assign cf  = f[1];
  assign sf  = f[2];
  assign of_ = f[3];

  always_comb begin
    sel_val = 1'b0;
    case (cond_sel_e'(cond_sel))
      COND_ZF:   sel_val = zf;
      COND_CF:   sel_val = cf;
      COND_SF:   sel_val = sf;
      COND_OF:   sel_val = of_;
      COND_LT:   sel_val = sf ^ of_;
      COND_LE:   sel_val = zf | (sf ^ of_);
      COND_BE:   sel_val = cf | zf;
      COND_DMA:  sel_val = dma_req;
      COND_MODE: sel_val = mode;
      COND_IRQ:  sel_val = int_pending & irq_en;
      COND_EXT:  sel_val = ext_cond;
      COND_TRUE: sel_val = 1'b1;
      default:   sel_val = 1'b0;
    endcase
  end

  assign cond_true = sel_val ^ cond_invert;

endmodule

// File: rtl/microsequencer.sv
// Next-address controller: decodes the sequencing fields of the current
// control word and registers the next micro-address for the u-ROM bank.
module microsequencer
  import pa_microcode::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CONTROL_WORD_WIDTH-1:0] cw,
  input  logic [7:0]                    ir_opcode,
  input  logic [3:0]                    flags,
  input  logic [3:0]                    u_flags,
  input  logic                          int_pending,
  input  logic                          irq_en,
  input  logic                          dma_req,
  input  logic                          mode,
  input  logic                          mem_wait,
  input  logic                          ext_cond,
  output logic [UADDR_W-1:0]            u_addr,
  output logic                          cond_true,
  output logic                          dispatch,
  output logic                          escape_active,
  output logic                          in_trap
);

  typ_e                 typ;
  logic [OFF_W-1:0]     offset;
  logic                 esc_bit;
  logic                 trap_req;
  logic                 cw_unused;

  logic [UADDR_W-1:0]   u_addr_q, u_addr_d;
  logic                 escape_q, escape_d;
  logic                 dispatch_q, dispatch_d;
  logic                 in_trap_q, in_trap_d;

  logic [UADDR_W-1:0]   addr_inc, addr_off, addr_br, addr_disp;

  assign typ       = typ_e'(cw[TYP_LSB +: TYP_W]);
  assign offset    = cw[OFF_LSB +: OFF_W];
  assign esc_bit   = cw[ESC_BIT];
  assign trap_req  = int_pending & irq_en;
  assign cw_unused = ^cw[CONTROL_WORD_WIDTH-1:ESC_BIT+1];

  cond_mux u_cond_mux (
    .cond_sel      (cw[CSEL_LSB +: CSEL_W]),
    .cond_invert   (cw[CINV_BIT]),
    .cond_flag_src (cw[CSRC_BIT]),
    .flags         (flags),
    .u_flags       (u_flags),
    .int_pending   (int_pending),
    .irq_en        (irq_en),
    .dma_req       (dma_req),
    .mode          (mode),
    .ext_cond      (ext_cond),
    .cond_true     (cond_true)
  );

  // Relative targets wrap modulo 2^UADDR_W; branch stays inside the 64-step page
  assign addr_inc  = u_addr_q + UADDR_W'(1);
  assign addr_off  = u_addr_q + {{(UADDR_W-OFF_W){offset[OFF_W-1]}}, offset};
  assign addr_br   = {u_addr_q[UADDR_W-1:6], offset[5:0]};
  assign addr_disp = {escape_q, ir_opcode, 6'd0};

  always_comb begin
    u_addr_d   = u_addr_q;
    escape_d   = escape_q;
    dispatch_d = 1'b0;
    in_trap_d  = in_trap_q;
    if (!mem_wait) begin
      in_trap_d = 1'b0;
      escape_d  = escape_q | esc_bit;
      case (typ)
        TYP_OFFSET: u_addr_d = cond_true ? addr_off : addr_inc;
        TYP_BRANCH: u_addr_d = cond_true ? addr_br  : addr_inc;
        TYP_DISPATCH: begin
          // The dispatch consumes the old latch; an escape bit here is dropped
          u_addr_d   = addr_disp;
          dispatch_d = 1'b1;
          escape_d   = 1'b0;
        end
        TYP_END: begin
          if (trap_req) begin
            u_addr_d  = TRAP_ENTRY;
            in_trap_d = 1'b1;
          end else begin
            u_addr_d  = FETCH_ENTRY;
          end
        end
        default: u_addr_d = addr_inc;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      u_addr_q   <= FETCH_ENTRY;
      escape_q   <= 1'b0;
      dispatch_q <= 1'b0;
      in_trap_q  <= 1'b0;
    end else begin
      u_addr_q   <= u_addr_d;
      escape_q   <= escape_d;
      dispatch_q <= dispatch_d;
      in_trap_q  <= in_trap_d;
    end
  end

  assign u_addr        = u_addr_q;
  assign dispatch      = dispatch_q;
  assign escape_active = escape_q;
  assign in_trap       = in_trap_q;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus random
// stimulus against a behavioural next-address model.
module tb_microsequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [111:0] cw = '0;
  logic [7:0]   ir_opcode = '0;
  logic [3:0]   flags = '0;
  logic [3:0]   u_flags = '0;
  logic         int_pending = 1'b0;
  logic         irq_en = 1'b0;
  logic         dma_req = 1'b0;
  logic         mode = 1'b0;
  logic         mem_wait = 1'b0;
  logic         ext_cond = 1'b0;
  logic [14:0]  u_addr;
  logic         cond_true;
  logic         dispatch;
  logic         escape_active;
  logic         in_trap;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state
  int m_ua   = 0;
  bit m_esc  = 0;
  bit m_disp = 0;
  bit m_trap = 0;

  microsequencer dut (
    .clk           (clk),
    .rst           (rst),
    .cw            (cw),
    .ir_opcode     (ir_opcode),
    .flags         (flags),
    .u_flags       (u_flags),
    .int_pending   (int_pending),
    .irq_en        (irq_en),
    .dma_req       (dma_req),
    .mode          (mode),
    .mem_wait      (mem_wait),
    .ext_cond      (ext_cond),
    .u_addr        (u_addr),
    .cond_true     (cond_true),
    .dispatch      (dispatch),
    .escape_active (escape_active),
    .in_trap       (in_trap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
  endtask

  // Sequencing fields: {esc, sel[3:0], src, inv, off[6:0], typ[1:0]}
  function automatic logic [15:0] mk(input logic [1:0] typ, input logic [6:0] off,
                                     input logic inv, input logic src,
                                     input logic [3:0] sel, input logic esc);
    return {esc, sel, src, inv, off, typ};
  endfunction

  function automatic bit ref_cond(input logic [15:0] lo);
    logic [3:0] f;
    bit z, c, s, o, r;
    f = lo[10] ? u_flags : flags;
    z = f[0]; c = f[1]; s = f[2]; o = f[3];
    case (int'(lo[14:11]))
      0:  r = z;
      1:  r = c;
      2:  r = s;
      3:  r = o;
      4:  r = s ^ o;
      5:  r = z | (s ^ o);
      6:  r = c | z;
      7:  r = dma_req;
      8:  r = mode;
      9:  r = int_pending & irq_en;
      10: r = ext_cond;
      11: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r ^ lo[9];
  endfunction

  task automatic check_outputs(input string tag);
    chk({tag, ".u_addr"},   32'(u_addr),        32'(m_ua));
    chk({tag, ".dispatch"}, 32'(dispatch),      32'(m_disp));
    chk({tag, ".in_trap"},  32'(in_trap),       32'(m_trap));
    chk({tag, ".escape"},   32'(escape_active), 32'(m_esc));
  endtask

  task automatic do_reset(input logic stall);
    @(negedge clk);
    rst      = 1'b1;
    mem_wait = stall;
    cw       = {$urandom(), $urandom(), $urandom(), 16'($urandom())};
    @(posedge clk);
    #1;
    m_ua = 0; m_esc = 0; m_disp = 0; m_trap = 0;
    chk("rst.u_addr",   32'(u_addr),        32'h0);
    chk("rst.escape",   32'(escape_active), 32'h0);
    chk("rst.dispatch", 32'(dispatch),      32'h0);
    chk("rst.in_trap",  32'(in_trap),       32'h0);
  endtask

  task automatic step(input logic [15:0] lo, input string tag);
    bit c;
    int o;
    @(negedge clk);
    rst = 1'b0;
    cw  = {$urandom(), $urandom(), $urandom(), lo};
    #1;
    c = ref_cond(lo);
    chk({tag, ".cond_true"}, 32'(cond_true), 32'(c));
    if (mem_wait) begin
      m_disp = 0;
    end else begin
      o = int'(lo[8:2]);
      if (o >= 64) o -= 128;
      m_disp = 0;
      m_trap = 0;
      case (int'(lo[1:0]))
        0: m_ua = c ? (m_ua + o + 32768) % 32768 : (m_ua + 1) % 32768;
        1: m_ua = c ? ((m_ua / 64) * 64 + int'(lo[7:2])) : (m_ua + 1) % 32768;
        2: begin
          m_ua   = (m_esc ? 16384 : 0) + int'(ir_opcode) * 64;
          m_disp = 1;
        end
        default: begin
          m_trap = int_pending & irq_en;
          m_ua   = m_trap ? 64 : 0;
        end
      endcase
      if (lo[1:0] == 2'b10) m_esc = 0;
      else if (lo[15])      m_esc = 1;
    end
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  initial begin
    do_reset(1'b1);
    mem_wait = 1'b0;

    // Escape then double dispatch of opcode 0x2A
    step(mk(2'b00, 7'd3, 0, 0, 4'd11, 0), "off3");
    chk("at_0003", 32'(u_addr), 32'h0003);
    step(mk(2'b00, 7'd0, 0, 0, 4'd12, 1), "esc");
    ir_opcode = 8'h2A;
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "disp1");
    chk("disp_esc", 32'(u_addr), 32'h4A80);
    chk("disp_pulse", 32'(dispatch), 32'h1);
    step(mk(2'b00, 7'd0, 0, 0, 4'd12, 0), "after_disp");
    chk("disp_drop", 32'(dispatch), 32'h0);
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "disp2");
    chk("disp_noesc", 32'(u_addr), 32'h0A80);

    // Negative offset, taken and not taken, from 0x0105
    ir_opcode = 8'h04;
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "d04a");
    step(mk(2'b00, 7'd5, 0, 0, 4'd11, 0), "to105a");
    step(mk(2'b00, 7'h7D, 0, 0, 4'd11, 0), "back3");
    chk("off_neg", 32'(u_addr), 32'h0102);
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "d04b");
    step(mk(2'b00, 7'd5, 0, 0, 4'd11, 0), "to105b");
    step(mk(2'b00, 7'h7D, 0, 0, 4'd12, 0), "nottaken");
    chk("off_inc", 32'(u_addr), 32'h0106);

    // In-page branch on ZF
    ir_opcode = 8'h05;
    flags     = 4'b0001;
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "d05a");
    step(mk(2'b01, 7'h15, 0, 0, 4'd0, 0), "br_zf");
    chk("branch", 32'(u_addr), 32'h0155);
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "d05b");
    step(mk(2'b01, 7'h15, 1, 0, 4'd0, 0), "br_inv");
    chk("branch_inv", 32'(u_addr), 32'h0141);

    // END with and without an enabled interrupt; DMA also raised
    int_pending = 1'b1; irq_en = 1'b1; dma_req = 1'b1;
    step(mk(2'b11, 7'd0, 0, 0, 4'd7, 0), "end_trap");
    chk("trap_addr", 32'(u_addr), 32'h0040);
    chk("trap_flag", 32'(in_trap), 32'h1);
    irq_en = 1'b0;
    step(mk(2'b11, 7'd0, 0, 0, 4'd11, 0), "end_fetch");
    chk("fetch_addr", 32'(u_addr), 32'h0000);
    int_pending = 1'b0; dma_req = 1'b0;

    // Stall holds for three cycles, then advances
    mem_wait = 1'b1;
    for (int i = 0; i < 3; i++) step(mk(2'b00, 7'd2, 0, 0, 4'd11, 0), "stall");
    chk("stall_hold", 32'(u_addr), 32'h0000);
    mem_wait = 1'b0;
    step(mk(2'b00, 7'd2, 0, 0, 4'd11, 0), "release");
    chk("stall_rel", 32'(u_addr), 32'h0002);

    // Wrap-around in both directions
    ir_opcode = 8'hFF;
    step(mk(2'b00, 7'd0, 0, 0, 4'd12, 1), "esc2");
    step(mk(2'b10, 7'd0, 0, 0, 4'd12, 0), "dFF");
    step(mk(2'b00, 7'h3F, 0, 0, 4'd11, 0), "to7fff");
    chk("at_7fff", 32'(u_addr), 32'h7FFF);
    step(mk(2'b00, 7'd0, 0, 0, 4'd12, 0), "wrap_up");
    chk("wrap_up", 32'(u_addr), 32'h0000);
    step(mk(2'b00, 7'h7F, 0, 0, 4'd11, 0), "wrap_dn");
    chk("wrap_dn", 32'(u_addr), 32'h7FFF);

    // Randomised run
    for (int i = 0; i < 600; i++) begin
      flags       = 4'($urandom());
      u_flags     = 4'($urandom());
      ir_opcode   = 8'($urandom());
      int_pending = 1'($urandom());
      irq_en      = 1'($urandom());
      dma_req     = 1'($urandom());
      mode        = 1'($urandom());
      ext_cond    = 1'($urandom());
      mem_wait    = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 59) == 0) do_reset(1'($urandom()));
      else step(16'($urandom()), "rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
